uart_rx_frame_decoder: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_frame_decoder_if.sv | 23 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_rx_frame_decoder.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_frame_decoder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver state encoding and the parity check.
// The transmitter and packet generator import this as well.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  // True when data plus parity bit do not give the expected parity (even: 0, odd: 1).
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                           input logic                 pbit,
                                           input logic                 even);
    logic expected;
    expected = even ? 1'b0 : 1'b1;
    return (^data ^ pbit) != expected;
  endfunction

endpackage

// File: rtl/uart_rx_frame_decoder_if.sv
// Receive-side bundle: serial line in, decoded byte and status strobes out.
// The decoder takes the slave modport; whoever drives the line takes the master modport.
interface uart_rx_frame_decoder_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output rx,
    input  rx_data, rx_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  rx,
    output rx_data, rx_valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator; restart_i realigns the phase to a line edge.
// Shared by the receive and transmit sides.
module uart_baud_tick #(
  parameter int TICK_DIV = 163
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_frame_decoder.sv
// 16x-oversampling UART receiver for start + 8 data (LSB first) + parity + stop frames.
// Good frames update rx_data with a one-cycle rx_valid; bad frames pulse parity_err or frame_err.
module uart_rx_frame_decoder
  import uart_pkg::*;
#(
  parameter int TICK_DIV    = 163,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_EVEN = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_rx_frame_decoder_if.slave   bus
);

  localparam int            TW       = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID      = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST     = TW'(OVERSAMPLE - 1);
  localparam int            BW       = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          EVEN     = (PARITY_EVEN != 0);

  logic                 rx_meta_q, rx_s_q;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic                 tick, restart, sample_pt, bit_end;

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_baud_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (restart),
    .tick_o    (tick)
  );

  assign sample_pt = tick && (tick_cnt_q == MID);
  assign bit_end   = tick && (tick_cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_meta_q    <= bus.rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // The start bit is confirmed at mid-bit but left to run to its end, so every later
  // bit spans counts 0..LAST and is sampled at MID.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    restart    = 1'b0;
    if (bit_end) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d    = START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          restart    = 1'b1;
        end
      end
      START: begin
        if (sample_pt && rx_s_q) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample_pt) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
        end
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (sample_pt) begin
          perr_d = parity_mismatch(shift_q, rx_s_q, EVEN);
        end
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample_pt) begin
          state_d = rx_s_q ? IDLE : BREAK;
        end
      end
      BREAK: begin
        // A full bit time of continuous idle is needed before a new start is trusted.
        if (!rx_s_q) begin
          tick_cnt_d = '0;
        end else if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    busy_d       = (state_q != IDLE);
    if ((state_q == STOP) && sample_pt) begin
      if (!rx_s_q) begin
        frame_err_d = 1'b1;
      end else if (perr_q) begin
        parity_err_d = 1'b1;
      end else begin
        rx_valid_d = 1'b1;
        rx_data_d  = shift_q;
      end
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Directed and random frames against a frame-level model of the receiver's outcomes.
module tb_uart_rx_frame_decoder;
  import uart_pkg::*;

  localparam int TD       = 4;
  localparam int BIT_CLKS = 16 * TD;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } event_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_frame_decoder_if bus ();

  uart_rx_frame_decoder #(
    .TICK_DIV    (TD),
    .OVERSAMPLE  (16),
    .PARITY_EVEN (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         checks        = 0;
  int         failures      = 0;
  int         cycle         = 0;
  int         validCycle    = 0;
  int         busyRiseCycle = 0;
  int         busyFallCycle = 0;
  int         checkedUpTo   = 0;
  logic       prevBusy      = 1'b0;
  logic [7:0] lastGood      = 8'h00;
  event_t     evQ[$];
  event_t     expQ[$];

  always @(posedge clk) cycle <= cycle + 1;

  // Observed strobes become events: 1 valid, 2 parity error, 3 framing error, 7 overlap.
  always @(negedge clk) begin
    int n;
    n = int'(bus.rx_valid === 1'b1) + int'(bus.parity_err === 1'b1) + int'(bus.frame_err === 1'b1);
    if (n > 1) begin
      evQ.push_back(event_t'{7, bus.rx_data});
    end else if (bus.rx_valid === 1'b1) begin
      evQ.push_back(event_t'{1, bus.rx_data});
      validCycle = cycle;
    end else if (bus.parity_err === 1'b1) begin
      evQ.push_back(event_t'{2, bus.rx_data});
    end else if (bus.frame_err === 1'b1) begin
      evQ.push_back(event_t'{3, bus.rx_data});
    end
    if (!prevBusy && (bus.busy === 1'b1)) busyRiseCycle = cycle;
    if (prevBusy && (bus.busy === 1'b0)) busyFallCycle = cycle;
    prevBusy = (bus.busy === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Frame-level model: even parity means the total count of ones in data+parity is even.
  task automatic expectFrame(input logic [7:0] data, input logic pbit, input logic stopBit);
    if (!stopBit) begin
      expQ.push_back(event_t'{3, lastGood});
    end else if (int'(pbit) != ($countones(data) % 2)) begin
      expQ.push_back(event_t'{2, lastGood});
    end else begin
      lastGood = data;
      expQ.push_back(event_t'{1, data});
    end
  endtask

  task automatic holdRx(input logic v, input int bits);
    bus.rx = v;
    repeat (bits * BIT_CLKS) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic pbit, input logic stopBit);
    logic [FRAME_BITS-1:0] frame;
    frame = {stopBit, pbit, data, 1'b0};
    expectFrame(data, pbit, stopBit);
    for (int i = 0; i < FRAME_BITS; i++) holdRx(frame[i], 1);
  endtask

  task automatic checkEvents(input string tag);
    int n;
    checkOutput({tag, "_count"}, 32'(evQ.size()), 32'(expQ.size()));
    n = (evQ.size() < expQ.size()) ? evQ.size() : expQ.size();
    for (int i = checkedUpTo; i < n; i++) begin
      checkOutput({tag, "_kind"}, 32'(evQ[i].kind), 32'(expQ[i].kind));
      checkOutput({tag, "_data"}, 32'(evQ[i].data), 32'(expQ[i].data));
    end
    if (n > checkedUpTo) checkedUpTo = n;
  endtask

  initial begin
    int         d;
    int         releaseCycle;
    int         kind;
    logic [7:0] data;
    logic       pbit;

    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rx_data", 32'(bus.rx_data), 32'h00);
    checkOutput("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
    checkOutput("reset_parity_err", 32'(bus.parity_err), 32'h0);
    checkOutput("reset_frame_err", 32'(bus.frame_err), 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    holdRx(1'b1, 1);

    applyStimulus(8'hA5, 1'b0, 1'b1);
    holdRx(1'b1, 2);
    checkEvents("good_a5");
    checkOutput("good_rx_data", 32'(bus.rx_data), 32'h A5);
    checkOutput("good_busy_fall_latency", 32'(busyFallCycle - validCycle), 32'd1);

    applyStimulus(8'h3C, 1'b1, 1'b1);
    holdRx(1'b1, 2);
    checkEvents("parity_3c");
    checkOutput("parity_rx_data_held", 32'(bus.rx_data), 32'h A5);

    applyStimulus(8'h55, 1'b0, 1'b0);
    holdRx(1'b0, 3);
    bus.rx       = 1'b1;
    releaseCycle = cycle;
    holdRx(1'b1, 2);
    checkEvents("break_55");
    d = busyFallCycle - releaseCycle;
    checkOutput("break_busy_window", 32'(d >= 16 * TD - 4 && d <= 16 * TD + 8), 32'd1);

    bus.rx = 1'b0;
    repeat (4 * TD) @(negedge clk);
    holdRx(1'b1, 2);
    checkEvents("glitch");
    d = busyFallCycle - busyRiseCycle;
    checkOutput("glitch_busy_len", 32'(busyRiseCycle > releaseCycle && d >= 1 && d <= 8 * TD + 2), 32'd1);
    checkOutput("glitch_idle", 32'(bus.busy), 32'h0);

    applyStimulus(8'h01, 1'b1, 1'b1);
    applyStimulus(8'hFE, 1'b1, 1'b1);
    holdRx(1'b1, 2);
    checkEvents("back_to_back");
    checkOutput("back_to_back_rx_data", 32'(bus.rx_data), 32'h FE);

    holdRx(1'b0, 1);
    holdRx(1'b1, 1);
    holdRx(1'b0, 1);
    holdRx(1'b0, 1);
    bus.rx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrst_busy", 32'(bus.busy), 32'h0);
    checkOutput("midrst_rx_data", 32'(bus.rx_data), 32'h00);
    rst_n    = 1'b1;
    lastGood = 8'h00;
    holdRx(1'b1, 2);
    applyStimulus(8'h42, 1'b0, 1'b1);
    holdRx(1'b1, 2);
    checkEvents("midrst_42");

    for (int k = 0; k < 12; k++) begin
      data = 8'($urandom_range(0, 255));
      kind = int'($urandom_range(0, 3));
      pbit = ^data;
      if (kind == 2) pbit = ~pbit;
      if (kind == 3) pbit = 1'($urandom_range(0, 1));
      applyStimulus(data, pbit, kind != 3);
      holdRx(1'b1, 2);
    end
    checkEvents("random");
    checkOutput("final_rx_data", 32'(bus.rx_data), 32'(lastGood));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
